// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
//   Loadable down counter with a small IDLE/RUN/DONE control FSM. A start
//   loads a value and runs the counter down one step per enabled cycle. When
//   it reaches zero, tc pulses for one cycle. The block then either finishes
//   in DONE, or (auto_reload) reloads the captured start value on the next
//   enabled cycle. All outputs come straight from registers.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   count-step qualifier while running
//   start        in   load-and-run request (restart when already running)
//   abort        in   return to IDLE; wins over start
//   load_value   in   [WIDTH] start value, captured only on an accepted start
//   auto_reload  in   periodic mode select, sampled at terminal count
//   count        out  [WIDTH] current count
//   busy         out  high while in RUN
//   done         out  high while in DONE
//   tc           out  one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic. Priority: abort, then start, then normal running.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      reload_d = load_value;
      count_d  = load_value;
      if (load_value == '0) begin
        // Nothing to count: terminate immediately, ignoring auto_reload.
        state_d = DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q == '0) begin
              // Only reachable after a terminal count in periodic mode:
              // reload instead of wrapping to all-ones.
              count_d = reload_q;
            end else if (count_q == WIDTH'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
              if (!auto_reload) begin
                state_d = DONE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        IDLE, DONE: begin
          // enable is ignored; count holds.
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    // Flags are registered copies of the next state so they line up with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// ---------------------------------------------------------------------------
// tb_down_counter
//   Table-driven bench for down_counter (WIDTH=4). Each table row holds the
//   inputs applied for one clock cycle and the outputs required just after
//   that edge. A hand-written periodic run with load_value=1 follows.
// ---------------------------------------------------------------------------
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, enable, start, abort, auto_reload;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, done, tc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .abort      (abort),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  typedef struct packed {
    logic         r;
    logic         s;
    logic         a;
    logic         e;
    logic         ar;
    logic [W-1:0] lv;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic a,
                     input logic e, input logic ar, input logic [W-1:0] lv,
                     input logic [W-1:0] cnt, input logic b,
                     input logic d, input logic t);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.e = e; v.ar = ar; v.lv = lv;
    v.cnt = cnt; v.busy = b; v.done = d; v.tc = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic a,
                       input logic e, input logic ar, input logic [W-1:0] lv);
    reset = r; start = s; abort = a; enable = e; auto_reload = ar;
    load_value = lv;
  endtask

  logic prev_tc;
  logic [W-1:0] exp_cnt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    //   r  s  a  e  ar lv    cnt  busy done tc
    // reset
    add(1, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
    // one-shot from 5
    add(0, 1, 0, 1, 0, 4'd5,  4'd5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 4'd9,  4'd0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 4'd9,  4'd0, 0, 1, 0);
    // periodic from 3; load_value changes mid-run must not leak in
    add(0, 1, 0, 1, 1, 4'd3,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd2, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 4'd7,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd2, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 4'd7,  4'd0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 4'd7,  4'd3, 1, 0, 0);
    // hold at 4 while enable is low
    add(0, 1, 0, 1, 0, 4'd6,  4'd6, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4'd6,  4'd4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4'd6,  4'd4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4'd6,  4'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd6,  4'd0, 0, 1, 1);
    // zero load, then repeated zero load (back-to-back tc allowed)
    add(0, 1, 0, 1, 1, 4'd0,  4'd0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 4'd0,  4'd0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 1, 0);
    // abort beats start at count 2; enable ignored in IDLE
    add(0, 1, 0, 1, 0, 4'd4,  4'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd4,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd4,  4'd2, 1, 0, 0);
    add(0, 1, 1, 1, 0, 4'd9,  4'd0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'd9,  4'd0, 0, 0, 0);
    // restart while running
    add(0, 1, 0, 1, 0, 4'd8,  4'd8, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd8,  4'd7, 1, 0, 0);
    add(0, 1, 0, 1, 0, 4'd3,  4'd3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd3,  4'd2, 1, 0, 0);
    // reset mid-run at count 3 overrides start/enable, then fresh run from 2
    add(0, 1, 0, 1, 0, 4'd5,  4'd5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd5,  4'd3, 1, 0, 0);
    add(1, 1, 0, 1, 0, 4'd5,  4'd0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 4'd2,  4'd2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd2,  4'd1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd2,  4'd0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 4'd2,  4'd0, 0, 1, 0);
    // abort from DONE
    add(0, 0, 1, 1, 0, 4'd2,  4'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].e, vecs[i].ar, vecs[i].lv);
      @(posedge clk);
      #1;
      $display("step %0d: r=%0b s=%0b a=%0b e=%0b ar=%0b lv=%0d -> count=%0d busy=%0b done=%0b tc=%0b",
               i, vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].e, vecs[i].ar,
               vecs[i].lv, count, busy, done, tc);
      check("count", i, count, vecs[i].cnt);
      check("busy",  i, W'(busy), W'(vecs[i].busy));
      check("done",  i, W'(done), W'(vecs[i].done));
      check("tc",    i, W'(tc),   W'(vecs[i].tc));
    end

    // Periodic run with load_value=1: count alternates 1,0,1,0...
    // tc must track count==0 and never be high on two consecutive cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
    @(posedge clk);
    #1;
    check("p1_start", 0, count, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    exp_cnt = 4'd1;
    prev_tc = tc;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt == 4'd1) ? 4'd0 : 4'd1;
      $display("p1 cycle %0d: count=%0d busy=%0b tc=%0b", k, count, busy, tc);
      check("p1_count", k, count, exp_cnt);
      check("p1_tc",    k, W'(tc), W'(exp_cnt == 4'd0));
      check("p1_busy",  k, W'(busy), W'(1'b1));
      check("p1_no_tc_pair", k, W'(prev_tc & tc), W'(1'b0));
      prev_tc = tc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
